// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit and its lane-alignment helper.
//   MEMOP_*  : RV funct3 encodings of the memory access size/extension
//   ERR_*    : response error codes returned on resp_err
//   ST_*     : LSU FSM state encodings
package lsu_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Stores have no zero-extending variant, so BU/HU are only legal on loads.
  function automatic logic memop_illegal(input logic [2:0] op, input logic wr);
    logic ill;
    ill = 1'b0;
    if (op == 3'b011 || op == 3'b110 || op == 3'b111) ill = 1'b1;
    if (wr && op[2]) ill = 1'b1;
    return ill;
  endfunction

  // Halfword needs a[0]=0, word needs a[1:0]=0; bytes are always aligned.
  function automatic logic memop_misaligned(input logic [2:0] op, input logic [1:0] a);
    logic mis;
    mis = 1'b0;
    if ((op == MEMOP_H || op == MEMOP_HU) && a[0]) mis = 1'b1;
    if (op == MEMOP_W && a != 2'b00) mis = 1'b1;
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for 32-bit little-endian memory.
//   i_op       : MemOP (funct3)
//   i_addr_lo  : byte offset within the word
//   i_wdata    : LSB-justified store data
//   i_rdata    : word-aligned load data from memory
//   o_wdata    : store data shifted to its byte lane
//   o_wstrb    : byte strobes for the access size (caller masks on loads)
//   o_rdata    : extracted and sign/zero-extended load data
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_rdata
);

  logic [4:0]  w_shamt;
  logic [31:0] w_rshift;

  assign w_shamt  = {i_addr_lo, 3'b000};
  assign o_wdata  = i_wdata << w_shamt;
  assign w_rshift = i_rdata >> w_shamt;

  always_comb begin
    o_wstrb = 4'b0000;
    o_rdata = i_rdata;
    case (i_op)
      MEMOP_B: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_rdata = {{24{w_rshift[7]}}, w_rshift[7:0]};
      end
      MEMOP_H: begin
        o_wstrb = 4'b0011 << i_addr_lo;
        o_rdata = {{16{w_rshift[15]}}, w_rshift[15:0]};
      end
      MEMOP_W: begin
        o_wstrb = 4'b1111;
        o_rdata = i_rdata;
      end
      MEMOP_BU: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_rdata = {24'h0, w_rshift[7:0]};
      end
      MEMOP_HU: begin
        o_wstrb = 4'b0011 << i_addr_lo;
        o_rdata = {16'h0, w_rshift[15:0]};
      end
      default: begin
        o_wstrb = 4'b0000;
        o_rdata = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit between execute and data memory.
//   i_clk, i_rst_n             : clock, async active-low reset
//   i_req_* / o_req_ready      : execute-side request (wr, op, addr, wdata)
//   o_resp_*                   : one-cycle response pulse with load data and error code
//   o_mem_* / i_mem_req_ready  : memory request channel (addr, wen, wdata, wstrb)
//   i_mem_resp_*               : memory response (read data / write ack)
// All outputs are registered. FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE; error ops go
// IDLE -> RESP directly without touching memory.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wr,
  input  logic [2:0]  i_req_op,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic [1:0]  o_resp_err,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_resp_valid,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [1:0]  r_state;
  logic        r_wr;
  logic [2:0]  r_op;
  logic [1:0]  r_addr_lo;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_rsp_data;
  logic [1:0]  r_rsp_err;

  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic [1:0]  r_resp_err;
  logic        r_mem_req_valid;
  logic [31:0] r_mem_addr;
  logic        r_mem_wen;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;

  logic [2:0]  w_al_op;
  logic [1:0]  w_al_lo;
  logic [31:0] w_al_wdata;
  logic [3:0]  w_al_wstrb;
  logic [31:0] w_al_rdata;
  logic [CW:0] w_cnt_inc;
  logic        w_timeout;

  // In IDLE the aligner shapes the incoming store; afterwards it extracts the load.
  assign w_al_op = (r_state == ST_IDLE) ? i_req_op : r_op;
  assign w_al_lo = (r_state == ST_IDLE) ? i_req_addr[1:0] : r_addr_lo;

  lsu_align u_align (
    .i_op      (w_al_op),
    .i_addr_lo (w_al_lo),
    .i_wdata   (i_req_wdata),
    .i_rdata   (i_mem_rdata),
    .o_wdata   (w_al_wdata),
    .o_wstrb   (w_al_wstrb),
    .o_rdata   (w_al_rdata)
  );

  // Abort once the cycle being spent in WAIT would be the TIMEOUT_CYC-th.
  assign w_cnt_inc = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};
  assign w_timeout = (TIMEOUT_CYC != 0) && (w_cnt_inc >= (CW + 1)'(TIMEOUT_CYC));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= ST_IDLE;
      r_wr            <= 1'b0;
      r_op            <= 3'b000;
      r_addr_lo       <= 2'b00;
      r_cnt           <= '0;
      r_rsp_data      <= 32'h0;
      r_rsp_err       <= ERR_OK;
      r_req_ready     <= 1'b1;
      r_resp_valid    <= 1'b0;
      r_resp_rdata    <= 32'h0;
      r_resp_err      <= ERR_OK;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= 32'h0;
      r_mem_wen       <= 1'b0;
      r_mem_wdata     <= 32'h0;
      r_mem_wstrb     <= 4'b0000;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= ERR_OK;
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_wr        <= i_req_wr;
            r_op        <= i_req_op;
            r_addr_lo   <= i_req_addr[1:0];
            r_cnt       <= '0;
            r_rsp_data  <= 32'h0;
            r_req_ready <= 1'b0;
            if (memop_illegal(i_req_op, i_req_wr)) begin
              r_rsp_err <= ERR_ILLEGAL;
              r_state   <= ST_RESP;
            end else if (memop_misaligned(i_req_op, i_req_addr[1:0])) begin
              r_rsp_err <= ERR_MISALIGN;
              r_state   <= ST_RESP;
            end else begin
              r_rsp_err       <= ERR_OK;
              r_mem_req_valid <= 1'b1;
              r_mem_addr      <= {i_req_addr[31:2], 2'b00};
              r_mem_wen       <= i_req_wr;
              r_mem_wdata     <= i_req_wr ? w_al_wdata : 32'h0;
              r_mem_wstrb     <= i_req_wr ? w_al_wstrb : 4'b0000;
              r_state         <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (i_mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_cnt           <= '0;
            r_state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_mem_resp_valid) begin
            r_rsp_err  <= ERR_OK;
            r_rsp_data <= r_wr ? 32'h0 : w_al_rdata;
            r_state    <= ST_RESP;
          end else if (w_timeout) begin
            r_rsp_err  <= ERR_TIMEOUT;
            r_rsp_data <= 32'h0;
            r_state    <= ST_RESP;
          end else if (!(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= r_rsp_data;
          r_resp_err   <= r_rsp_err;
          r_req_ready  <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready     = r_req_ready;
  assign o_resp_valid    = r_resp_valid;
  assign o_resp_rdata    = r_resp_rdata;
  assign o_resp_err      = r_resp_err;
  assign o_mem_req_valid = r_mem_req_valid;
  assign o_mem_addr      = r_mem_addr;
  assign o_mem_wen       = r_mem_wen;
  assign o_mem_wdata     = r_mem_wdata;
  assign o_mem_wstrb     = r_mem_wstrb;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  int n_vec;
  int n_fail;

  lsu #(.TIMEOUT_CYC(4)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_wr         (req_wr),
    .i_req_op         (req_op),
    .i_req_addr       (req_addr),
    .i_req_wdata      (req_wdata),
    .o_resp_valid     (resp_valid),
    .o_resp_rdata     (resp_rdata),
    .o_resp_err       (resp_err),
    .o_mem_req_valid  (mem_req_valid),
    .i_mem_req_ready  (mem_req_ready),
    .o_mem_addr       (mem_addr),
    .o_mem_wen        (mem_wen),
    .o_mem_wdata      (mem_wdata),
    .o_mem_wstrb      (mem_wstrb),
    .i_mem_resp_valid (mem_resp_valid),
    .i_mem_rdata      (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus driver: issues one op from a negedge, plays the memory side, and returns
  // what it observed. lat counts negedges after the issue edge until resp_valid is seen
  // (4 = resp high after edge 3 of a minimum-latency op).
  task automatic do_op(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int hold,
                       input bit respond, output logic seen, output logic [31:0] m_addr,
                       output logic [31:0] m_wdata, output logic [3:0] m_strb,
                       output logic m_wen, output logic stable, output logic [31:0] r_data,
                       output logic [1:0] r_err, output int lat);
    seen = 1'b0; m_addr = 'x; m_wdata = 'x; m_strb = 'x; m_wen = 1'bx; stable = 1'b1;
    req_valid = 1'b1; req_wr = wr; req_op = op; req_addr = addr; req_wdata = wdata;
    lat = 0;
    @(negedge clk); lat++;
    req_valid = 1'b0;
    if (mem_req_valid) begin
      seen = 1'b1; m_addr = mem_addr; m_wdata = mem_wdata; m_strb = mem_wstrb; m_wen = mem_wen;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk); lat++;
        if (!mem_req_valid || mem_addr !== m_addr || mem_wdata !== m_wdata ||
            mem_wstrb !== m_strb || mem_wen !== m_wen || req_ready !== 1'b0) stable = 1'b0;
      end
      mem_req_ready = 1'b1;
      @(negedge clk); lat++;
      mem_req_ready = 1'b0;
      if (respond) begin
        mem_resp_valid = 1'b1; mem_rdata = rdata;
        @(negedge clk); lat++;
        mem_resp_valid = 1'b0; mem_rdata = 32'h0;
      end
    end
    while (!resp_valid && lat < 40) begin
      @(negedge clk); lat++;
    end
    r_data = resp_rdata; r_err = resp_err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    n_vec++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata got %h exp 0", resp_rdata); end
    n_vec++; if (resp_err !== 2'b00) begin n_fail++; $display("FAIL reset_resp_err got %b exp 00", resp_err); end
    n_vec++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_valid got %b exp 0", mem_req_valid); end
    n_vec++; if ({mem_addr, mem_wdata, mem_wstrb, mem_wen} !== 69'h0) begin n_fail++; $display("FAIL reset_mem_outs got %h %h %b %b exp zeros", mem_addr, mem_wdata, mem_wstrb, mem_wen); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_load_word();
    logic seen, wen, st; logic [31:0] ma, mw, rd; logic [3:0] sb; logic [1:0] er; int lat;
    do_op(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, seen, ma, mw, sb, wen, st, rd, er, lat);
    n_vec++; if (seen !== 1'b1) begin n_fail++; $display("FAIL lw_mem_req got %b exp 1", seen); end
    n_vec++; if (ma !== 32'h8000_0010) begin n_fail++; $display("FAIL lw_mem_addr got %h exp 80000010", ma); end
    n_vec++; if ({wen, sb} !== 5'b0_0000) begin n_fail++; $display("FAIL lw_wen_strb got %b %b exp 0 0000", wen, sb); end
    n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata got %h exp deadbeef", rd); end
    n_vec++; if (er !== 2'b00) begin n_fail++; $display("FAIL lw_err got %b exp 00", er); end
    n_vec++; if (lat !== 4) begin n_fail++; $display("FAIL lw_min_latency got %0d exp 4", lat); end
  endtask

  task automatic test_load_extend();
    logic seen, wen, st; logic [31:0] ma, mw, rd; logic [3:0] sb; logic [1:0] er; int lat;
    logic [2:0]  ops [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] adr [5] = '{32'h8000_0013, 32'h8000_0013, 32'h8000_0002, 32'h8000_0002, 32'h8000_0001};
    logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h0000_007F};
    for (int i = 0; i < 5; i++) begin
      do_op(1'b0, ops[i], adr[i], 32'h0, 32'h80FF_7F01, 0, 1'b1, seen, ma, mw, sb, wen, st, rd, er, lat);
      n_vec++; if (rd !== exp[i] || er !== 2'b00) begin n_fail++; $display("FAIL load_ext[%0d] got %h/%b exp %h/00", i, rd, er, exp[i]); end
      n_vec++; if (ma !== {adr[i][31:2], 2'b00}) begin n_fail++; $display("FAIL load_ext_addr[%0d] got %h", i, ma); end
    end
  endtask

  task automatic test_store();
    logic seen, wen, st; logic [31:0] ma, mw, rd; logic [3:0] sb; logic [1:0] er; int lat;
    logic [2:0]  ops [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] adr [3] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0104};
    logic [31:0] wd  [3] = '{32'h0000_ABCD, 32'h0000_00A5, 32'h1234_5678};
    logic [31:0] ewd [3] = '{32'hABCD_0000, 32'h0000_A500, 32'h1234_5678};
    logic [3:0]  esb [3] = '{4'b1100, 4'b0010, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, ops[i], adr[i], wd[i], 32'hFFFF_FFFF, 0, 1'b1, seen, ma, mw, sb, wen, st, rd, er, lat);
      n_vec++; if (mw !== ewd[i]) begin n_fail++; $display("FAIL store_wdata[%0d] got %h exp %h", i, mw, ewd[i]); end
      n_vec++; if (sb !== esb[i] || wen !== 1'b1) begin n_fail++; $display("FAIL store_strb_wen[%0d] got %b %b exp %b 1", i, sb, wen, esb[i]); end
      n_vec++; if (rd !== 32'h0 || er !== 2'b00) begin n_fail++; $display("FAIL store_resp[%0d] got %h/%b exp 0/00", i, rd, er); end
    end
  endtask

  task automatic test_errors();
    logic seen, wen, st; logic [31:0] ma, mw, rd; logic [3:0] sb; logic [1:0] er; int lat;
    logic        wrs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  ops [5] = '{3'b010, 3'b001, 3'b010, 3'b100, 3'b011};
    logic [31:0] adr [5] = '{32'h8000_0001, 32'h8000_0003, 32'h8000_0002, 32'h8000_0000, 32'h8000_0000};
    logic [1:0]  ee  [5] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b11};
    for (int i = 0; i < 5; i++) begin
      do_op(wrs[i], ops[i], adr[i], 32'h5555_5555, 32'h0, 0, 1'b1, seen, ma, mw, sb, wen, st, rd, er, lat);
      n_vec++; if (seen !== 1'b0) begin n_fail++; $display("FAIL err_no_mem_req[%0d] got %b exp 0", i, seen); end
      n_vec++; if (er !== ee[i] || rd !== 32'h0) begin n_fail++; $display("FAIL err_code[%0d] got %b/%h exp %b/0", i, er, rd, ee[i]); end
      n_vec++; if (lat !== 2) begin n_fail++; $display("FAIL err_latency[%0d] got %0d exp 2", i, lat); end
    end
  endtask

  task automatic test_hold();
    logic seen, wen, st; logic [31:0] ma, mw, rd; logic [3:0] sb; logic [1:0] er; int lat;
    do_op(1'b1, 3'b000, 32'h8000_0023, 32'h0000_0099, 32'h0, 5, 1'b1, seen, ma, mw, sb, wen, st, rd, er, lat);
    n_vec++; if (st !== 1'b1) begin n_fail++; $display("FAIL hold_stable got %b exp 1", st); end
    n_vec++; if (mw !== 32'h9900_0000 || sb !== 4'b1000) begin n_fail++; $display("FAIL hold_lane got %h %b exp 99000000 1000", mw, sb); end
    n_vec++; if (lat !== 9) begin n_fail++; $display("FAIL hold_latency got %0d exp 9", lat); end
  endtask

  task automatic test_timeout();
    logic seen, wen, st; logic [31:0] ma, mw, rd; logic [3:0] sb; logic [1:0] er; int lat;
    logic late_seen;
    do_op(1'b0, 3'b010, 32'h8000_0040, 32'h0, 32'h0, 0, 1'b0, seen, ma, mw, sb, wen, st, rd, er, lat);
    n_vec++; if (er !== 2'b10 || rd !== 32'h0) begin n_fail++; $display("FAIL timeout_err got %b/%h exp 10/0", er, rd); end
    n_vec++; if (lat !== 7) begin n_fail++; $display("FAIL timeout_latency got %0d exp 7", lat); end
    // Late response arriving in IDLE must be dropped.
    mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    late_seen = resp_valid;
    @(negedge clk);
    late_seen = late_seen | resp_valid;
    n_vec++; if (late_seen !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL late_resp_dropped got %b ready %b exp 0 1", late_seen, req_ready); end
  endtask

  task automatic test_reset_mid_op();
    logic seen, wen, st; logic [31:0] ma, mw, rd; logic [3:0] sb; logic [1:0] er; int lat;
    req_valid = 1'b1; req_wr = 1'b1; req_op = 3'b010; req_addr = 32'h8000_0080; req_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++; if ({req_ready, resp_valid, mem_req_valid, mem_wen} !== 4'b1000) begin n_fail++; $display("FAIL midrst_ctrl got %b exp 1000", {req_ready, resp_valid, mem_req_valid, mem_wen}); end
    n_vec++; if ({mem_addr, mem_wdata, mem_wstrb, resp_rdata, resp_err} !== 102'h0) begin n_fail++; $display("FAIL midrst_data got %h %h %b exp zeros", mem_addr, mem_wdata, mem_wstrb); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h0BAD_CAFE, 0, 1'b1, seen, ma, mw, sb, wen, st, rd, er, lat);
    n_vec++; if (rd !== 32'h0BAD_CAFE || er !== 2'b00 || lat !== 4) begin n_fail++; $display("FAIL post_rst_lw got %h/%b/%0d exp 0badcafe/00/4", rd, er, lat); end
  endtask

  initial begin
    n_vec = 0; n_fail = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_op = 3'b000; req_addr = 32'h0;
    req_wdata = 32'h0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_load_word();
    test_load_extend();
    test_store();
    test_errors();
    test_hold();
    test_timeout();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
